// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with HI/LO registers (radix-2, WIDTH+1 cycles per op).
// Optional macro EARLY_TERM_EN: multiplies stop once the remaining multiplier bits are zero.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             hi_wr,
    input  logic             lo_wr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             hilo_rd,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             stall_req,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               is_div_q, is_div_d, sgn_q, sgn_d;
    logic               neg_a_q, neg_a_d, neg_b_q, neg_b_d, div0_q, div0_d;
    logic [WIDTH-1:0]   acc_q, acc_d, lq_q, lq_d, opb_q, opb_d;
`ifdef EARLY_TERM_EN
    logic [WIDTH-1:0]   mplr_q, mplr_d;
`endif

    logic [WIDTH-1:0]   mul_add;
    logic [WIDTH:0]     mul_sum, rem_sh, trial;
    logic [2*WIDTH-1:0] mag, prod;
    logic [WIDTH-1:0]   quot, remd;
    logic               last;

    function automatic logic [WIDTH-1:0] abs_val(input logic signed [WIDTH-1:0] v,
                                                 input logic sgn);
        return (sgn && v < 0) ? -v : v;
    endfunction

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        hi_d     = hi_q;
        lo_d     = lo_q;
        is_div_d = is_div_q;
        sgn_d    = sgn_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        div0_d   = div0_q;
        acc_d    = acc_q;
        lq_d     = lq_q;
        opb_d    = opb_q;
`ifdef EARLY_TERM_EN
        mplr_d   = mplr_q;
`endif

        // Multiply consumes the multiplier from lq's LSB; divide shifts the dividend out of its MSB.
        mul_add = lq_q[0] ? opb_q : {WIDTH{1'b0}};
        mul_sum = {1'b0, acc_q} + {1'b0, mul_add};
        rem_sh  = {acc_q, lq_q[WIDTH-1]};
        trial   = rem_sh - {1'b0, opb_q};
        last    = (cnt_q == CW'(WIDTH - 1));
`ifdef EARLY_TERM_EN
        if (!is_div_q && mplr_q[WIDTH-1:1] == '0) last = 1'b1;
        mag = {acc_q, lq_q} >> (CW'(WIDTH) - cnt_q);
`else
        mag = {acc_q, lq_q};
`endif
        prod = neg_2w(mag, sgn_q & (neg_a_q ^ neg_b_q));
        quot = neg_w(lq_q, sgn_q & (neg_a_q ^ neg_b_q));
        remd = neg_w(acc_q, sgn_q & neg_a_q);

        case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    state_d  = RUN;
                    cnt_d    = '0;
                    is_div_d = op[1];
                    sgn_d    = ~op[0];
                    neg_a_d  = ~op[0] & src_a[WIDTH-1];
                    neg_b_d  = ~op[0] & src_b[WIDTH-1];
                    div0_d   = (src_b == '0);
                    acc_d    = '0;
                    lq_d     = op[1] ? abs_val(src_a, ~op[0]) : abs_val(src_b, ~op[0]);
                    opb_d    = op[1] ? abs_val(src_b, ~op[0]) : abs_val(src_a, ~op[0]);
`ifdef EARLY_TERM_EN
                    mplr_d   = abs_val(src_b, ~op[0]);
`endif
                end else if (!start) begin
                    if (hi_wr) hi_d = wr_data;
                    if (lo_wr) lo_d = wr_data;
                end
            end
            RUN: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (is_div_q) begin
                        if (!trial[WIDTH]) begin
                            acc_d = trial[WIDTH-1:0];
                            lq_d  = {lq_q[WIDTH-2:0], 1'b1};
                        end else begin
                            acc_d = rem_sh[WIDTH-1:0];
                            lq_d  = {lq_q[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        acc_d = mul_sum[WIDTH:1];
                        lq_d  = {mul_sum[0], lq_q[WIDTH-1:1]};
                    end
`ifdef EARLY_TERM_EN
                    mplr_d = mplr_q >> 1;
`endif
                    if (last) state_d = FIX;
                end
            end
            FIX: begin
                state_d = IDLE;
                if (!flush) begin
                    done_d = 1'b1;
                    if (is_div_q) begin
                        hi_d = remd;
                        lo_d = div0_q ? {WIDTH{1'b1}} : quot;
                    end else begin
                        hi_d = prod[2*WIDTH-1:WIDTH];
                        lo_d = prod[WIDTH-1:0];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Datapath registers carry no reset; they are reloaded on every accepted start.
    always_ff @(posedge clk) begin
        is_div_q <= is_div_d;
        sgn_q    <= sgn_d;
        neg_a_q  <= neg_a_d;
        neg_b_q  <= neg_b_d;
        div0_q   <= div0_d;
        acc_q    <= acc_d;
        lq_q     <= lq_d;
        opb_q    <= opb_d;
`ifdef EARLY_TERM_EN
        mplr_q   <= mplr_d;
`endif
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign stall_req = busy & (start | hilo_rd);

endmodule
